// File: rtl/velocity_cell_updater.sv
// velocity_cell_updater: read-modify-write sequencer for one cell's velocity memory.
// Define VEL_UPDATER_STALL_CNT_EN to add the stall_cycles output port.
module velocity_cell_updater #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
`ifdef VEL_UPDATER_STALL_CNT_EN
  output logic [15:0]           stall_cycles,
`endif
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] v_out,
  output logic [ADDR_WIDTH-1:0] v_out_pid,
  output logic                  v_out_valid,
  input  logic                  v_out_ready,
  input  logic [DATA_WIDTH-1:0] v_in,
  input  logic                  v_in_valid,
  output logic                  v_in_ready
);

  localparam logic [ADDR_WIDTH-1:0] MAX_CNT =
    ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_CNT,
    S_LAT_CNT,
    S_RD_V,
    S_LAT_V,
    S_SEND,
    S_RECV,
    S_WR,
    S_FIN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] i_q, i_d;
  logic [ADDR_WIDTH-1:0] pid_q, pid_d;
  logic [DATA_WIDTH-1:0] vout_q, vout_d;
  logic [DATA_WIDTH-1:0] vin_q, vin_d;
  logic [ADDR_WIDTH-1:0] cnt_raw;
  logic [ADDR_WIDTH-1:0] cnt_clamp;

  // Clamping the count keeps i from ever wrapping past the memory depth.
  assign cnt_raw   = mem_q[ADDR_WIDTH-1:0];
  assign cnt_clamp = (cnt_raw > MAX_CNT) ? MAX_CNT : cnt_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      i_q     <= '0;
      pid_q   <= '0;
      vout_q  <= '0;
      vin_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      pid_q   <= pid_d;
      vout_q  <= vout_d;
      vin_q   <= vin_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    i_d         = i_q;
    pid_d       = pid_q;
    vout_d      = vout_q;
    vin_d       = vin_q;
    busy        = (state_q != S_IDLE);
    done        = 1'b0;
    mem_address = '0;
    mem_data    = '0;
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    v_out_valid = 1'b0;
    v_in_ready  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RD_CNT;
      end
      S_RD_CNT: begin
        mem_rden = 1'b1;
        state_d  = S_LAT_CNT;
      end
      S_LAT_CNT: begin
        cnt_d   = cnt_clamp;
        i_d     = ADDR_WIDTH'(1);
        state_d = (cnt_clamp == '0) ? S_FIN : S_RD_V;
      end
      S_RD_V: begin
        mem_address = i_q;
        mem_rden    = 1'b1;
        state_d     = S_LAT_V;
      end
      S_LAT_V: begin
        vout_d  = mem_q;
        pid_d   = i_q;
        state_d = S_SEND;
      end
      S_SEND: begin
        v_out_valid = 1'b1;
        if (v_out_ready) state_d = S_RECV;
      end
      S_RECV: begin
        v_in_ready = 1'b1;
        if (v_in_valid) begin
          vin_d   = v_in;
          state_d = S_WR;
        end
      end
      S_WR: begin
        mem_address = i_q;
        mem_data    = vin_q;
        mem_wren    = 1'b1;
        if (i_q == cnt_q) begin
          state_d = S_FIN;
        end else begin
          i_d     = i_q + ADDR_WIDTH'(1);
          state_d = S_RD_V;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign particle_count = cnt_q;
  assign v_out          = vout_q;
  assign v_out_pid      = pid_q;

`ifdef VEL_UPDATER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  logic        stall_hit;

  assign stall_hit =
    ((state_q == S_SEND) && !v_out_ready) ||
    ((state_q == S_RECV) && !v_in_valid);

  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && start) begin
      stall_d = '0;
    end else if (stall_hit && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_velocity_cell_updater.sv
// Scoreboard bench for velocity_cell_updater with a behavioural memory
// and a consumer that returns v+1 after programmable per-particle delays.
module tb_velocity_cell_updater;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] particle_count;
`ifdef VEL_UPDATER_STALL_CNT_EN
  logic [15:0]   stall_cycles;
`endif
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_rden;
  logic          mem_wren;
  logic [DW-1:0] mem_q;
  logic [DW-1:0] v_out;
  logic [AW-1:0] v_out_pid;
  logic          v_out_valid;
  logic          v_out_ready;
  logic [DW-1:0] v_in;
  logic          v_in_valid;
  logic          v_in_ready;

  always #5 clk = ~clk;

  velocity_cell_updater #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .PARTICLE_NUM(PN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .busy(busy),
    .done(done),
    .particle_count(particle_count),
`ifdef VEL_UPDATER_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .mem_address(mem_address),
    .mem_data(mem_data),
    .mem_rden(mem_rden),
    .mem_wren(mem_wren),
    .mem_q(mem_q),
    .v_out(v_out),
    .v_out_pid(v_out_pid),
    .v_out_valid(v_out_valid),
    .v_out_ready(v_out_ready),
    .v_in(v_in),
    .v_in_valid(v_in_valid),
    .v_in_ready(v_in_ready)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          exp_vout[$];
  ent_t          exp_wr[$];
  logic [DW-1:0] mem [0:255];
  int            rdy_dly [0:255];
  int            vin_dly [0:255];
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_done = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_strobes"},
        128'({busy, done, mem_rden, mem_wren, v_out_valid, v_in_ready}),
        128'(0));
    chk({nm, "_pcount"}, 128'(particle_count), 128'(0));
    chk({nm, "_addr"}, 128'(mem_address), 128'(0));
    chk({nm, "_wdata"}, 128'(mem_data), 128'(0));
    chk({nm, "_vout"}, 128'(v_out), 128'(0));
    chk({nm, "_pid"}, 128'(v_out_pid), 128'(0));
`ifdef VEL_UPDATER_STALL_CNT_EN
    chk({nm, "_stall"}, 128'(stall_cycles), 128'(0));
`endif
  endtask

  // Memory: 1-cycle read latency, write applied at the clock edge.
  initial begin : memory
    logic          rd, wr;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    mem_q = '0;
    forever begin
      @(negedge clk);
      rd = mem_rden;
      wr = mem_wren;
      ad = mem_address;
      wd = mem_data;
      if (rd || wr) begin
        chk("addr_range", 128'(int'(ad) < PN), 128'(1));
        chk("rd_wr_excl", 128'(rd && wr), 128'(0));
      end
      if (wr) chk("wr_word0", 128'(ad == '0), 128'(0));
      @(posedge clk);
      #1;
      if (rd) mem_q = mem[ad];
      if (wr && rst_n) mem[ad] = wd;
    end
  end

  // Consumer: pulls v_out, then returns v_out+1.
  initial begin : consumer
    int            cst, cnt;
    logic [AW-1:0] cur;
    logic [DW-1:0] got;
    cst = 0; cnt = 0; cur = '0; got = '0;
    v_out_ready = 1'b0;
    v_in_valid  = 1'b0;
    v_in        = '0;
    forever begin
      @(posedge clk);
      #1;
      v_out_ready = 1'b0;
      v_in_valid  = 1'b0;
      if (!rst_n) begin
        cst = 0;
        cnt = 0;
      end else begin
        case (cst)
          0: if (v_out_valid) begin
            if (cnt < rdy_dly[v_out_pid]) cnt++;
            else begin
              v_out_ready = 1'b1;
              got = v_out;
              cur = v_out_pid;
              cst = 1;
              cnt = 0;
            end
          end
          1: if (cnt < vin_dly[cur]) cnt++;
          else begin
            v_in       = got + 96'd1;
            v_in_valid = 1'b1;
            cst        = 2;
          end
          default: begin
            cst = 0;
            cnt = 0;
          end
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and write.
  initial begin : monitor
    logic          pv;
    logic [DW-1:0] pvo;
    logic [AW-1:0] ppid;
    ent_t          e;
    pv = 1'b0; pvo = '0; ppid = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (v_out_valid || v_in_ready)
          chk("vld_rdy_excl", 128'(v_out_valid && v_in_ready), 128'(0));
        if (pv && v_out_valid) begin
          chk("vout_stable", 128'(v_out), 128'(pvo));
          chk("pid_stable", 128'(v_out_pid), 128'(ppid));
        end
        if (v_out_valid && v_out_ready) begin
          n_cmp++;
          if (exp_vout.size() == 0) begin
            n_err++;
            $display("FAIL vout_unexpected: got pid %0d expected none",
                     v_out_pid);
          end else begin
            n_cmp--;
            e = exp_vout.pop_front();
            chk("vout_pid", 128'(v_out_pid), 128'(e.a));
            chk("vout_data", 128'(v_out), 128'(e.d));
          end
        end
        pv = v_out_valid && !v_out_ready;
        pvo = v_out;
        ppid = v_out_pid;
        if (mem_wren) begin
          n_cmp++;
          if (exp_wr.size() == 0) begin
            n_err++;
            $display("FAIL wr_unexpected: got addr %0d expected none",
                     mem_address);
          end else begin
            n_cmp--;
            e = exp_wr.pop_front();
            chk("wr_addr", 128'(mem_address), 128'(e.a));
            chk("wr_data", 128'(mem_data), 128'(e.d));
          end
        end
        if (done) n_done++;
      end
    end
  end

  task automatic run_cell(input string nm, input logic [DW-1:0] w0,
                          input int exp_pc, input int exp_cyc,
                          input int restart_at);
    int c, d0;
    bit seen;
    mem[0] = w0;
    for (int p = 1; p <= exp_pc; p++) begin
      exp_vout.push_back('{a: AW'(p), d: mem[p]});
      exp_wr.push_back('{a: AW'(p), d: mem[p] + 96'd1});
    end
    d0 = n_done;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c = 1;
    seen = 1'b0;
    while (!seen && c < 3000) begin
      @(negedge clk);
      start = (c == restart_at);
      if (c == 1) chk({nm, "_busy_on"}, 128'(busy), 128'(1));
      if (done) seen = 1'b1;
      else c++;
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, 128'(seen), 128'(1));
    chk({nm, "_cycles"}, 128'(c), 128'(exp_cyc));
    chk({nm, "_pcount"}, 128'(particle_count), 128'(exp_pc));
    @(negedge clk);
    chk({nm, "_busy_off"}, 128'(busy), 128'(0));
    repeat (10) @(negedge clk);
    chk({nm, "_done_pulses"}, 128'(n_done - d0), 128'(1));
    chk({nm, "_vout_left"}, 128'(exp_vout.size()), 128'(0));
    chk({nm, "_wr_left"}, 128'(exp_wr.size()), 128'(0));
    chk({nm, "_word0"}, 128'(mem[0]), 128'(w0));
  endtask

  initial begin : main
    logic [DW-1:0] old1, old2, old219, old220;
    int            c;
    rst_n = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 256; k++) begin
      mem[k] = {32'(k), 32'(k * 3), ~32'(k)};
      rdy_dly[k] = 0;
      vin_dly[k] = 0;
    end
    #1;
    chk_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Three particles, free-flowing consumer.
    mem[1] = 96'h00000001_00000002_00000003;
    mem[2] = 96'h00000000_00000000_FFFFFFFF;
    mem[3] = 96'hDEADBEEF_12345678_9ABCDEF0;
    run_cell("t1", 96'd3, 3, 18, -1);
    chk("t1_m1", 128'(mem[1]), 128'(96'h00000001_00000002_00000004));
    chk("t1_m2", 128'(mem[2]), 128'(96'h00000000_00000001_00000000));
    chk("t1_m3", 128'(mem[3]), 128'(96'hDEADBEEF_12345678_9ABCDEF1));

    // Empty cell.
    run_cell("t2", 96'd0, 0, 3, -1);

    // Count above depth is clamped.
    old219 = mem[219];
    old220 = mem[220];
    run_cell("t3", 96'd250, 219, 1098, -1);
    chk("t3_m219", 128'(mem[219]), 128'(old219 + 96'd1));
    chk("t3_m220", 128'(mem[220]), 128'(old220));

    // Backpressure on particle 1: 4 ready-low + 3 valid-low cycles.
    rdy_dly[1] = 4;
    vin_dly[1] = 3;
    old1 = mem[1];
    old2 = mem[2];
    run_cell("t4", 96'd2, 2, 20, -1);
    rdy_dly[1] = 0;
    vin_dly[1] = 0;
    chk("t4_m1", 128'(mem[1]), 128'(old1 + 96'd1));
    chk("t4_m2", 128'(mem[2]), 128'(old2 + 96'd1));
`ifdef VEL_UPDATER_STALL_CNT_EN
    chk("t4_stall", 128'(stall_cycles), 128'(7));
`endif

    // Second start while busy is ignored.
    run_cell("t5", 96'd3, 3, 18, 5);

    // Reset while waiting for particle 2's update.
    old1 = mem[1];
    old2 = mem[2];
    vin_dly[2] = 10;
    mem[0] = 96'd3;
    for (int p = 1; p <= 2; p++) begin
      exp_vout.push_back('{a: AW'(p), d: mem[p]});
      exp_wr.push_back('{a: AW'(p), d: mem[p] + 96'd1});
    end
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c = 0;
    while (!(v_in_ready && v_out_pid == AW'(2)) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("t6_reach_recv2", 128'(v_in_ready && v_out_pid == AW'(2)),
        128'(1));
    #1 rst_n = 1'b0;
    #1;
    chk_zero("t6_abort");
    exp_vout.delete();
    exp_wr.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vin_dly[2] = 0;
    chk("t6_m1", 128'(mem[1]), 128'(old1 + 96'd1));
    chk("t6_m2", 128'(mem[2]), 128'(old2));

    // Fresh start after the abort.
    run_cell("t7", 96'd3, 3, 18, -1);
    chk("t7_m2", 128'(mem[2]), 128'(old2 + 96'd1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
